reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//   Parametrised successor to the 8x16 LC-3 register file: DEPTH x WIDTH array, two
//   combinational read ports (SR1/SR2), one synchronous write port (DR).
//   Adds optional write-to-read bypass, a per-register busy scoreboard for
//   outstanding loads, and a sequential clear-all sweep with start/done handshake.
//   Sits in the datapath between the bus/MDR write-back and the ALU operand inputs.
// PARAMETERS
//   WIDTH      16  data width of each register
//   DEPTH      8   number of registers; power of two, >=2; AW = $clog2(DEPTH) (localparam)
//   BYPASS     1   1: read port returns D when writing the same register this cycle
//   RESET_VAL  0   value loaded into every register on reset (WIDTH bits)
// PORTS
//   Clk        in   1      clock, rising edge
//   Reset_n    in   1      asynchronous active-low reset
//   D          in   WIDTH  write data
//   DR         in   AW     destination register index
//   LD_REG     in   1      write enable: reg[DR] <= D at the clock edge
//   SR1        in   AW     read port 1 index
//   SR2        in   AW     read port 2 index
//   SR1_OUT    out  WIDTH  read data port 1 (combinational)
//   SR2_OUT    out  WIDTH  read data port 2 (combinational)
//   Mark_Busy  in   1      set busy bit of register Mark_Addr (load issued)
//   Mark_Addr  in   AW     register to mark busy
//   SR1_Busy   out  1      busy bit of reg[SR1] (combinational)
//   SR2_Busy   out  1      busy bit of reg[SR2] (combinational)
//   Clr_Start  in   1      request clear-all sweep (sampled in IDLE only)
//   Clr_Busy   out  1      high while sweep in progress
//   Clr_Done   out  1      one-cycle pulse after the last register is cleared
// BEHAVIOUR
//   Reset (async, Reset_n=0): all regs <= RESET_VAL, all busy bits <= 0, FSM <= IDLE,
//     index <= 0, Clr_Busy=0, Clr_Done=0. SRx_OUT then show RESET_VAL.
//   Reset asserted mid-sweep aborts it immediately; no Clr_Done is produced.
//   Read: SRx_OUT = reg[SRx]; with BYPASS=1, FSM=IDLE, LD_REG=1 and DR==SRx ->
//     SRx_OUT = D (same cycle). Both ports may select the same reg; both bypass.
//   Write: FSM=IDLE and LD_REG=1 -> reg[DR] <= D at the edge, busy[DR] <= 0.
//   Scoreboard: FSM=IDLE and Mark_Busy=1 -> busy[Mark_Addr] <= 1.
//     Mark_Busy and LD_REG on the same register in the same cycle: data written,
//     busy ends 1 (mark wins). Different registers: both take effect.
//   SRx_Busy reflect the registered busy bit; bypass does not clear them combinationally.
//   FSM states: IDLE, SWEEP, DONE.
//     IDLE : Clr_Start=1 -> SWEEP, index <= 0, all busy bits <= 0.
//     SWEEP: each cycle reg[index] <= 0 (zero, not RESET_VAL), index <= index+1;
//            at index==DEPTH-1 -> DONE. Clr_Busy=1 in SWEEP.
//     DONE : Clr_Done=1 for exactly one cycle -> IDLE.
//   Clr_Start at edge t: regs zeroed on edges t+1..t+DEPTH, Clr_Done high during
//     cycle after edge t+DEPTH, IDLE again after edge t+DEPTH+1.
//   Outside IDLE: LD_REG, Mark_Busy, Clr_Start ignored (dropped, not queued);
//     bypass disabled; reads return current array contents.
//   Clr_Start held high across DONE->IDLE starts a new sweep on the first IDLE cycle.
//   index counter is AW bits; no wrap beyond DEPTH-1 since FSM leaves SWEEP there.
// TESTING
//   1 Reset: Reset_n=0 with RESET_VAL=16'hA5A5 -> all 8 reads 16'hA5A5, SRx_Busy=0.
//   2 Write/readback + bypass: LD_REG=1, DR=3, D=16'h1234, SR1=3 -> SR1_OUT=16'h1234
//     same cycle; next cycle LD_REG=0 -> SR1_OUT=16'h1234; BYPASS=0 -> old value same cycle.
//   3 Scoreboard: Mark_Busy, Mark_Addr=5 -> SR2=5 gives SR2_Busy=1; later LD_REG DR=5
//     -> SR2_Busy=0; Mark_Busy+LD_REG both on reg 2 same cycle -> data written, busy=1.
//   4 Sweep: fill regs with 16'hFFFF, pulse Clr_Start -> Clr_Busy high 8 cycles, regs
//     zero in order 0..7, Clr_Done 1 cycle, LD_REG DR=1 during sweep leaves reg1=0.
//   5 Reset mid-sweep: assert Reset_n=0 after 3 sweep cycles -> Clr_Busy=0 immediately,
//     no Clr_Done, all regs RESET_VAL.
//   6 Params: WIDTH=32, DEPTH=16 -> sweep lasts 16 cycles, write/read on reg 15 correct.

Source files
------------

// File: rtl/reg_file_sb.sv
// DEPTH x WIDTH register file with two combinational read ports, one write port,
// optional write-to-read bypass, a load-busy scoreboard and a clear-all sweep.
module reg_file_sb #(
    parameter int                 WIDTH     = 16,
    parameter int                 DEPTH     = 8,
    parameter int                 BYPASS    = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                AW        = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    DR,
    input  logic             LD_REG,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    input  logic             Mark_Busy,
    input  logic [AW-1:0]    Mark_Addr,
    output logic             SR1_Busy,
    output logic             SR2_Busy,
    input  logic             Clr_Start,
    output logic             Clr_Busy,
    output logic             Clr_Done
);

    // state    | meaning
    // ST_IDLE  | normal operation: writes, marks and clear requests accepted
    // ST_SWEEP | zeroing one register per cycle, index idx_q
    // ST_DONE  | one-cycle Clr_Done pulse, then back to idle
    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             byp_en;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (LD_REG) begin
                    regs_d[DR] = D;
                    busy_d[DR] = 1'b0;
                end
                // mark after write so a same-register mark wins over the write's clear
                if (Mark_Busy) begin
                    busy_d[Mark_Addr] = 1'b1;
                end
                if (Clr_Start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    busy_d  = '0;
                end
            end
            ST_SWEEP: begin
                regs_d[idx_q] = '0;
                idx_d         = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            regs_q  <= regs_d;
        end
    end

    assign byp_en   = (BYPASS != 0) && (state_q == ST_IDLE) && LD_REG;
    assign SR1_OUT  = (byp_en && (DR == SR1)) ? D : regs_q[SR1];
    assign SR2_OUT  = (byp_en && (DR == SR2)) ? D : regs_q[SR2];
    assign SR1_Busy = busy_q[SR1];
    assign SR2_Busy = busy_q[SR2];
    assign Clr_Busy = (state_q == ST_SWEEP);
    assign Clr_Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass/no-bypass 8x16 instances with shared
// stimulus and a 16x32 instance for the parametrised sweep and hold-start cases.
module tb_reg_file_sb;

    logic        Clk = 1'b0;
    logic        Reset_n;

    logic [15:0] D;
    logic [2:0]  DR, SR1, SR2, Mark_Addr;
    logic        LD_REG, Mark_Busy, Clr_Start;
    logic [15:0] a_sr1, a_sr2, b_sr1, b_sr2;
    logic        a_b1, a_b2, a_cb, a_cd, b_b1, b_b2, b_cb, b_cd;

    logic [31:0] c_d, c_sr1_out, c_sr2_out;
    logic [3:0]  c_dr, c_sr1, c_sr2, c_maddr;
    logic        c_ld, c_mark, c_start, c_b1, c_b2, c_cb, c_cd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    reg_file_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .RESET_VAL(16'hA5A5)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .D(D), .DR(DR), .LD_REG(LD_REG),
        .SR1(SR1), .SR2(SR2), .SR1_OUT(a_sr1), .SR2_OUT(a_sr2),
        .Mark_Busy(Mark_Busy), .Mark_Addr(Mark_Addr), .SR1_Busy(a_b1), .SR2_Busy(a_b2),
        .Clr_Start(Clr_Start), .Clr_Busy(a_cb), .Clr_Done(a_cd));

    reg_file_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .RESET_VAL(16'hA5A5)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .D(D), .DR(DR), .LD_REG(LD_REG),
        .SR1(SR1), .SR2(SR2), .SR1_OUT(b_sr1), .SR2_OUT(b_sr2),
        .Mark_Busy(Mark_Busy), .Mark_Addr(Mark_Addr), .SR1_Busy(b_b1), .SR2_Busy(b_b2),
        .Clr_Start(Clr_Start), .Clr_Busy(b_cb), .Clr_Done(b_cd));

    reg_file_sb #(.WIDTH(32), .DEPTH(16), .BYPASS(1), .RESET_VAL(32'h0)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .D(c_d), .DR(c_dr), .LD_REG(c_ld),
        .SR1(c_sr1), .SR2(c_sr2), .SR1_OUT(c_sr1_out), .SR2_OUT(c_sr2_out),
        .Mark_Busy(c_mark), .Mark_Addr(c_maddr), .SR1_Busy(c_b1), .SR2_Busy(c_b2),
        .Clr_Start(c_start), .Clr_Busy(c_cb), .Clr_Done(c_cd));

    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] d;
        logic        mark;
        logic [2:0]  maddr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] enb1;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle_a();
        LD_REG = 1'b0; DR = '0; D = '0; Mark_Busy = 1'b0; Mark_Addr = '0;
        Clr_Start = 1'b0; SR1 = '0; SR2 = '0;
    endtask

    task automatic check_all_a(input string name, input logic [15:0] exp);
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(7 - i);
            #1;
            chk({name, "_sr1"}, 32'(a_sr1), 32'(exp));
            chk({name, "_sr2"}, 32'(a_sr2), 32'(exp));
            chk({name, "_busy1"}, 32'(a_b1), 32'd0);
        end
    endtask

    task automatic wait_c_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk); #1;
            if (c_cd) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int busy_cnt;

        //            ld    dr    d         mk    ma    sr1   sr2   e1        e2        enb1      eb1   eb2
        vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd0, 16'h1234, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd3, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd5, 3'd5, 16'h5555, 16'h5555, 16'hA5A5, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd3, 16'h5555, 16'h1234, 16'h5555, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'd2, 16'hBEEF, 1'b1, 3'd2, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF, 16'hA5A5, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5, 16'hBEEF, 16'h5555, 16'hBEEF, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd6, 16'h0606, 1'b1, 3'd7, 3'd6, 3'd7, 16'h0606, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd7, 16'h0606, 16'hA5A5, 16'h0606, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 3'd0, 16'hCAFE, 1'b0, 3'd0, 3'd0, 3'd0, 16'hCAFE, 16'hCAFE, 16'hA5A5, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd2, 16'hCAFE, 16'hBEEF, 16'hCAFE, 1'b0, 1'b1};

        idle_a();
        c_d = '0; c_dr = '0; c_sr1 = '0; c_sr2 = '0; c_maddr = '0;
        c_ld = 1'b0; c_mark = 1'b0; c_start = 1'b0;

        // reset state
        Reset_n = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check_all_a("rst", 16'hA5A5);
        chk("rst_clr_busy", 32'(a_cb), 32'd0);
        chk("rst_clr_done", 32'(a_cd), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // table vectors: bypass, scoreboard, same-cycle mark/write
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            LD_REG = vecs[i].ld; DR = vecs[i].dr; D = vecs[i].d;
            Mark_Busy = vecs[i].mark; Mark_Addr = vecs[i].maddr;
            SR1 = vecs[i].sr1; SR2 = vecs[i].sr2;
            #1;
            chk($sformatf("v%0d_sr1", i), 32'(a_sr1), 32'(vecs[i].e1));
            chk($sformatf("v%0d_sr2", i), 32'(a_sr2), 32'(vecs[i].e2));
            chk($sformatf("v%0d_nobyp_sr1", i), 32'(b_sr1), 32'(vecs[i].enb1));
            chk($sformatf("v%0d_busy1", i), 32'(a_b1), 32'(vecs[i].eb1));
            chk($sformatf("v%0d_busy2", i), 32'(a_b2), 32'(vecs[i].eb2));
        end

        // sweep: fill with FFFF, mark reg 4 busy, then clear-all
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            LD_REG = 1'b1; DR = 3'(i); D = 16'hFFFF;
            Mark_Busy = (i == 7); Mark_Addr = 3'd4;
        end
        @(negedge Clk);
        idle_a();
        Clr_Start = 1'b1; SR1 = 3'd4;
        #1;
        chk("pre_sweep_busy4", 32'(a_b1), 32'd1);
        chk("pre_sweep_clr_busy", 32'(a_cb), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            Clr_Start = 1'b0;
            LD_REG = (k == 3); DR = 3'd1; D = 16'h1111;
            Mark_Busy = (k == 3); Mark_Addr = 3'd1;
            SR1 = 3'(k);
            SR2 = (k == 3) ? 3'd1 : 3'(k == 0 ? 0 : k - 1);
            #1;
            chk($sformatf("sw%0d_clr_busy", k), 32'(a_cb), 32'd1);
            chk($sformatf("sw%0d_clr_done", k), 32'(a_cd), 32'd0);
            chk($sformatf("sw%0d_pending", k), 32'(a_sr1), 32'hFFFF);
            chk($sformatf("sw%0d_cleared", k), 32'(a_sr2), (k == 0) ? 32'hFFFF : 32'h0);
            chk($sformatf("sw%0d_busy", k), 32'(a_b1), 32'd0);
        end
        @(negedge Clk);
        idle_a();
        SR1 = 3'd1; SR2 = 3'd7;
        #1;
        chk("done_pulse", 32'(a_cd), 32'd1);
        chk("done_clr_busy", 32'(a_cb), 32'd0);
        chk("done_reg1_write_dropped", 32'(a_sr1), 32'h0);
        chk("done_reg7_zero", 32'(a_sr2), 32'h0);
        chk("done_busy1_mark_dropped", 32'(a_b1), 32'd0);
        @(negedge Clk); #1;
        chk("post_done_low", 32'(a_cd), 32'd0);
        chk("post_clr_busy_low", 32'(a_cb), 32'd0);
        check_all_a("after_sweep", 16'h0000);

        // reset in the middle of a sweep
        @(negedge Clk);
        LD_REG = 1'b1; DR = 3'd3; D = 16'h7777;
        @(negedge Clk);
        idle_a();
        Clr_Start = 1'b1;
        @(negedge Clk);
        Clr_Start = 1'b0;
        repeat (3) @(negedge Clk);
        SR1 = 3'd3;
        #1;
        chk("mid_sweep_reg3", 32'(a_sr1), 32'h7777);
        chk("mid_sweep_clr_busy", 32'(a_cb), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("abort_clr_busy", 32'(a_cb), 32'd0);
        chk("abort_reg3", 32'(a_sr1), 32'hA5A5);
        for (int n = 0; n < 4; n++) begin
            @(negedge Clk); #1;
            chk("abort_no_done_rst", 32'(a_cd), 32'd0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge Clk); #1;
            chk("abort_no_done", 32'(a_cd), 32'd0);
            chk("abort_idle", 32'(a_cb), 32'd0);
        end
        check_all_a("after_abort", 16'hA5A5);

        // 16 x 32 instance
        @(negedge Clk);
        c_ld = 1'b1; c_dr = 4'd15; c_d = 32'hDEADBEEF; c_sr1 = 4'd15; c_sr2 = 4'd14;
        #1;
        chk("c_bypass_r15", c_sr1_out, 32'hDEADBEEF);
        chk("c_r14_reset", c_sr2_out, 32'h0);
        @(negedge Clk);
        c_ld = 1'b0;
        #1;
        chk("c_readback_r15", c_sr1_out, 32'hDEADBEEF);
        @(negedge Clk);
        c_start = 1'b1;
        @(negedge Clk);
        c_start = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            #1;
            if (c_cb) busy_cnt++;
            if (c_cd) seen = 1'b1;
            else @(negedge Clk);
        end
        chk("c_done_seen", 32'(seen), 32'd1);
        chk("c_busy_cycles", 32'(busy_cnt), 32'd16);
        c_sr1 = 4'd15; c_sr2 = 4'd0;
        #1;
        chk("c_r15_zero", c_sr1_out, 32'h0);

        // Clr_Start held through DONE restarts on the first idle cycle
        @(negedge Clk);
        c_start = 1'b1;
        wait_c_done(seen);
        chk("c_hold_first_done", 32'(seen), 32'd1);
        @(negedge Clk); #1;
        chk("c_hold_idle_gap_busy", 32'(c_cb), 32'd0);
        chk("c_hold_idle_gap_done", 32'(c_cd), 32'd0);
        @(negedge Clk); #1;
        chk("c_hold_restart", 32'(c_cb), 32'd1);
        c_start = 1'b0;
        wait_c_done(seen);
        chk("c_hold_second_done", 32'(seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
